// File: rtl/line_follower_ctrl_if.sv
// Sensor/servo bundle of the line-follower drive controller.
// No valid/ready handshake: en and sensors are level signals sampled on every
// rising clk edge; servo_l, servo_r, state_o and lost are registered levels
// that are valid in every cycle after reset.
interface line_follower_ctrl_if #(
   parameter int SENSOR_W = 4,
   parameter int SPD_W    = 8
);
   logic                en;
   logic [SENSOR_W-1:0] sensors;
   logic [SPD_W-1:0]    servo_l;
   logic [SPD_W-1:0]    servo_r;
   logic [2:0]          state_o;
   logic                lost;

   // Controller side: consumes the sensor bar, produces drive codes.
   modport slave (
      input  en, sensors,
      output servo_l, servo_r, state_o, lost
   );

   // Environment side: sensor synchroniser / enable source and servo PWM.
   modport master (
      output en, sensors,
      input  servo_l, servo_r, state_o, lost
   );
endinterface

// File: rtl/line_follower_ctrl.sv
// Line-follower drive controller: decodes the reflectance sensor bar into
// forward / timed turn / search / stop manoeuvres and drives the servo speed
// codes. Optional build macro LINE_FOLLOWER_RAMP_EN slew-limits the servo
// outputs by RAMP_STEP per clk (zero targets in IDLE/STOP stay immediate).
// state_o exposes the state register directly for debug.
module line_follower_ctrl #(
   parameter int SENSOR_W   = 4,
   parameter int SPD_W      = 8,
   parameter int FWD_L      = 155,
   parameter int FWD_R      = 137,
   parameter int SOFT_INNER = 60,
   parameter int TURN_CYC   = 500,
   parameter int LOST_CYC   = 4000,
   parameter int CNT_W      = 21,
   parameter int RAMP_STEP  = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   line_follower_ctrl_if.slave bus
);

   localparam int HALF = SENSOR_W / 2;
   // One spare bit keeps the popcount width at least 2 for the smallest bar.
   localparam int PC_W = $clog2(HALF + 1) + 1;

   localparam logic [SPD_W-1:0] SPD_FWD_L = SPD_W'(FWD_L);
   localparam logic [SPD_W-1:0] SPD_FWD_R = SPD_W'(FWD_R);
   localparam logic [SPD_W-1:0] SPD_SOFT  = SPD_W'(SOFT_INNER);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
   localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_CYC - 1);

   // Reject parameter sets the datapath cannot represent.
   if ((SENSOR_W < 2) || (SENSOR_W % 2 != 0)) begin : g_bad_sensor_w
      $error("SENSOR_W must be even and >= 2");
   end
   if ((TURN_CYC < 1) || (LOST_CYC < 1) || (RAMP_STEP < 1)) begin : g_bad_timing
      $error("TURN_CYC, LOST_CYC and RAMP_STEP must be >= 1");
   end
   if ((TURN_CYC > (1 << CNT_W)) || (LOST_CYC > (1 << CNT_W))) begin : g_bad_cnt_w
      $error("CNT_W too narrow for TURN_CYC/LOST_CYC");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FWD    = 3'd1,
      TURN_L = 3'd2,
      TURN_R = 3'd3,
      SEARCH = 3'd4,
      STOP   = 3'd7
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             last_left, last_left_nx;
   logic [SPD_W-1:0] tgt_l, tgt_r, tgt_l_nx, tgt_r_nx;
   logic [SPD_W-1:0] servo_l, servo_r;
   logic             lost;

   logic [PC_W-1:0]  pop_l, pop_r, pop_diff;
   logic             none, go_left, go_right, hard;

`ifdef LINE_FOLLOWER_RAMP_EN
   localparam logic [SPD_W-1:0] RAMP_S = SPD_W'(RAMP_STEP);

   // Move one speed code toward its target by at most RAMP_S.
   function automatic logic [SPD_W-1:0] ramp_to(input logic [SPD_W-1:0] cur,
                                                 input logic [SPD_W-1:0] tgt);
      logic [SPD_W-1:0] res;
      res = tgt;
      if ((tgt > cur) && ((tgt - cur) > RAMP_S)) res = cur + RAMP_S;
      if ((cur > tgt) && ((cur - tgt) > RAMP_S)) res = cur - RAMP_S;
      return res;
   endfunction
`endif

   // Sensor bar decode: count hits on each half and classify the line position.
   always_comb begin
      pop_l = '0;
      pop_r = '0;
      for (int i = 0; i < HALF; i++) begin
         pop_r = pop_r + PC_W'(bus.sensors[i]);
         pop_l = pop_l + PC_W'(bus.sensors[HALF + i]);
      end
      none     = (bus.sensors == '0);
      go_left  = (pop_l > pop_r);
      go_right = (pop_r > pop_l);
      pop_diff = go_left ? (pop_l - pop_r) : (pop_r - pop_l);
      hard     = (pop_diff >= PC_W'(2));
   end

   // Next state, remembered turn direction and wheel targets of the state entered.
   always_comb begin
      state_nx     = state;
      last_left_nx = last_left;
      tgt_l_nx     = tgt_l;
      tgt_r_nx     = tgt_r;
      if (!bus.en) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:   state_nx = FWD;
            FWD: begin
               if (none) begin
                  state_nx = SEARCH;
               end else if (go_left) begin
                  state_nx     = TURN_L;
                  last_left_nx = 1'b1;
                  tgt_l_nx     = hard ? '0 : SPD_SOFT;
                  tgt_r_nx     = SPD_FWD_R;
               end else if (go_right) begin
                  state_nx     = TURN_R;
                  last_left_nx = 1'b0;
                  tgt_l_nx     = SPD_FWD_L;
                  tgt_r_nx     = hard ? '0 : SPD_SOFT;
               end
            end
            TURN_L, TURN_R: if (cnt == TURN_LAST) state_nx = FWD;
            SEARCH: begin
               if (!none)                  state_nx = FWD;
               else if (cnt == LOST_LAST)  state_nx = STOP;
            end
            STOP:   if (!none) state_nx = FWD;
            default: state_nx = IDLE;
         endcase
      end
      // Turn targets were latched above on entry; every other state has fixed targets.
      case (state_nx)
         FWD: begin
            tgt_l_nx = SPD_FWD_L;
            tgt_r_nx = SPD_FWD_R;
         end
         SEARCH: begin
            tgt_l_nx = last_left_nx ? '0 : SPD_FWD_L;
            tgt_r_nx = last_left_nx ? SPD_FWD_R : '0;
         end
         TURN_L, TURN_R: ;
         default: begin
            tgt_l_nx = '0;
            tgt_r_nx = '0;
         end
      endcase
   end

   // State register, saturating hold counter and registered drive outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         last_left <= 1'b1;
         tgt_l     <= '0;
         tgt_r     <= '0;
         servo_l   <= '0;
         servo_r   <= '0;
         lost      <= 1'b0;
      end else begin
         state     <= state_nx;
         last_left <= last_left_nx;
         tgt_l     <= tgt_l_nx;
         tgt_r     <= tgt_r_nx;
         if (state_nx != state) begin
            cnt <= '0;
         end else if (((state == TURN_L) || (state == TURN_R)) && (cnt != TURN_LAST)) begin
            cnt <= cnt + CNT_W'(1);
         end else if ((state == SEARCH) && (cnt != LOST_LAST)) begin
            cnt <= cnt + CNT_W'(1);
         end
`ifdef LINE_FOLLOWER_RAMP_EN
         if ((state_nx == IDLE) || (state_nx == STOP)) begin
            servo_l <= '0;
            servo_r <= '0;
         end else begin
            servo_l <= ramp_to(servo_l, tgt_l_nx);
            servo_r <= ramp_to(servo_r, tgt_r_nx);
         end
`else
         servo_l <= tgt_l_nx;
         servo_r <= tgt_r_nx;
`endif
         lost <= (state_nx == SEARCH) || (state_nx == STOP);
      end
   end

   assign bus.servo_l = servo_l;
   assign bus.servo_r = servo_r;
   assign bus.state_o = state;
   assign bus.lost    = lost;

endmodule
